pipe_addsub: RTL



---
 rtl/pipe_adder_pkg.sv | 16 +
 rtl/pipe_add_slice.sv | 54 +++++
 rtl/pipe_addsub.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor family.
package pipe_adder_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

    // Operation select encoding for the sub input.
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Width of the operand slice resolved by each pipeline stage.
    function automatic int SLICE_W(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipe_add_slice.sv
// One pipeline stage of the adder: a C-bit adder whose sum, carry-out,
// overflow and valid bit are registered. en_i is the global hold enable;
// while it is low every register keeps its value.
module pipe_add_slice #(
    parameter int C = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         vld_i,
    input  logic [C-1:0] a_i,
    input  logic [C-1:0] b_i,
    input  logic         c_i,
    output logic         vld_o,
    output logic [C-1:0] sum_o,
    output logic         c_o,
    output logic         ov_o
);

    logic [C:0] full_d;
    logic       cmsb_d;
    logic       vld_q;
    logic [C-1:0] sum_q;
    logic       c_q;
    logic       ov_q;

    // Slice sum with carry out; the carry into the slice MSB is recovered
    // from the MSB sum bit so overflow is available for the top slice.
    always_comb begin
        full_d = {1'b0, a_i} + {1'b0, b_i} + {{C{1'b0}}, c_i};
        cmsb_d = a_i[C-1] ^ b_i[C-1] ^ full_d[C-1];
    end

    // Stage registers: cleared by reset, held while the pipe is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            sum_q <= '0;
            c_q   <= 1'b0;
            ov_q  <= 1'b0;
        end else if (en_i) begin
            vld_q <= vld_i;
            sum_q <= full_d[C-1:0];
            c_q   <= full_d[C];
            ov_q  <= cmsb_d ^ full_d[C];
        end
    end

    assign vld_o = vld_q;
    assign sum_o = sum_q;
    assign c_o   = c_q;
    assign ov_o  = ov_q;

endmodule

// File: rtl/pipe_addsub.sv
// Parametrised valid/ready pipelined adder/subtractor.
// Operands are cut into STAGES slices of WIDTH/STAGES bits; stage k adds
// slice k and hands a registered carry to stage k+1. Upper operand slices
// ride in skew registers until their stage, and finished low result slices
// ride in the same registers (shifted in from the top) so s emerges whole.
//
// Handshake: a beat is accepted when in_valid & in_ready; a result is
// consumed when out_valid & out_ready. The pipe stalls globally whenever a
// result is presented but not consumed: every register (data and valid)
// holds, so outputs stay stable and in_ready is low for that cycle.
//
// Optional feature: define PIPE_ADDSUB_SAT_EN to saturate s to the signed
// max/min on overflow (no extra latency; co and ov are unaffected).
module pipe_addsub
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);

    localparam int C = SLICE_W(WIDTH, STAGES);

    if (WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("pipe_addsub: WIDTH must be a multiple of STAGES");
    end

    logic             adv;
    logic             vld_w [STAGES];
    logic [C-1:0]     sum_w [STAGES];
    logic             cy_w  [STAGES];
    logic             ov_w  [STAGES];
    logic [WIDTH-1:0] w_in  [STAGES];
    logic [WIDTH-1:0] w_d   [STAGES];
    logic [WIDTH-1:0] w_q   [STAGES];
    logic [WIDTH-1:0] w_out [STAGES];
    logic [WIDTH-1:0] b_in  [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_raw;

    // Global stall: the whole pipe advances only when the output is free.
    always_comb begin
        adv      = ~(out_valid & ~out_ready);
        in_ready = adv;
    end

    // Stage inputs: stage 0 sees the raw operands (b pre-inverted for
    // subtract), later stages see the previous stage's skew words.
    always_comb begin
        w_in[0] = a;
        b_in[0] = (sub == MODE_SUB) ? ~b : b;
        for (int k = 1; k < STAGES; k++) begin
            w_in[k] = w_out[k-1];
            b_in[k] = b_q[k-1];
        end
    end

    // Skew next-state drops the consumed slice; a stage's visible word
    // places its freshly registered sum slice in the vacated top bits.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_d[k]   = w_in[k] >> C;
            b_d[k]   = b_in[k] >> C;
            w_out[k] = w_q[k] | (WIDTH'(sum_w[k]) << (WIDTH - C));
        end
    end

    // Skew/deskew registers, held together with the slices on a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                w_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                w_q[k] <= w_d[k];
                b_q[k] <= b_d[k];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic vld_in;
        logic cy_in;
        if (k == 0) begin : g_first
            // Subtract is a + ~b + ~ci, so the borrow-in is inverted here.
            assign vld_in = in_valid;
            assign cy_in  = ci ^ (sub == MODE_SUB);
        end else begin : g_rest
            assign vld_in = vld_w[k-1];
            assign cy_in  = cy_w[k-1];
        end
        pipe_add_slice #(.C(C)) u_slice (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (adv),
            .vld_i (vld_in),
            .a_i   (w_in[k][C-1:0]),
            .b_i   (b_in[k][C-1:0]),
            .c_i   (cy_in),
            .vld_o (vld_w[k]),
            .sum_o (sum_w[k]),
            .c_o   (cy_w[k]),
            .ov_o  (ov_w[k])
        );
    end

    assign s_raw     = w_out[STAGES-1];
    assign out_valid = vld_w[STAGES-1];
    assign co        = cy_w[STAGES-1];
    assign ov        = ov_w[STAGES-1];

`ifdef PIPE_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Saturating output mux. On overflow the wrapped sign is the inverse of
    // a's sign, so a positive a (wrapped MSB 1) clamps to max, else to min.
    always_comb begin
        s = s_raw;
        if (ov) begin
            s = s_raw[WIDTH-1] ? SMAX : SMIN;
        end
    end
`else
    assign s = s_raw;
`endif

endmodule
